// File: rtl/count_monitor_pkg.sv
// Shared types, defaults and helpers for the counter-stream receive checker.
package count_monitor_pkg;

  localparam int CM_WIDTH  = 8;
  localparam int CM_LOCK_N = 4;
  localparam int CM_LOSS_N = 3;
  localparam int CM_ERR_W  = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } cm_state_e;

  // prev+1 reduced modulo 2^w; callers narrow the 32-bit result to their width
  function automatic logic [31:0] next_expected(input logic [31:0] prev, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    return (prev + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an event leaves 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] q_q, q_d;

  // next count: clear wins over the old value, the event still counts
  always_comb begin
    q_d = q_q;
    if (clr)                    q_d = inc ? W'(1) : '0;
    else if (inc && q_q != MAX) q_d = q_q + W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/count_monitor.sv
// Receive-side checker: locks onto an incrementing counter stream and
// reports lock status, per-mismatch pulses and a saturating error count.
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH  = CM_WIDTH,
  parameter int LOCK_N = CM_LOCK_N,
  parameter int LOSS_N = CM_LOSS_N,
  parameter int ERR_W  = CM_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);
  localparam logic [3:0] LOSS_C = 4'(LOSS_N);

  cm_state_e        state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       bad_q, bad_d;
  // Holds prev+1 directly; prev itself is never needed beyond the prediction.
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sample, match, err_inc;

  // next-state, counters and prediction for one sample
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    bad_d      = bad_q;
    expected_d = expected_q;
    err_inc    = 1'b0;
    sample     = en && cnt_valid;
    match      = (cnt_in == expected_q);
    if (sample) begin
      expected_d = WIDTH'(next_expected(32'(cnt_in), WIDTH));
      unique case (state_q)
        SEARCH: begin
          good_d  = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (match) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_inc = 1'b1;
            if (LOSS_N == 1) state_d = SEARCH;
            else begin
              bad_d   = 4'd1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (match) begin
            bad_d   = '0;
            state_d = LOCKED;
          end else begin
            err_inc = 1'b1;
            bad_d   = bad_q + 4'd1;
            if (bad_q + 4'd1 == LOSS_C) state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d    = (state_d == LOCKED) || (state_d == HOLD);
    err_pulse_d = err_inc;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      good_q      <= '0;
      bad_q       <= '0;
      expected_q  <= WIDTH'(1);
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      expected_q  <= expected_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // en low freezes the error count too, clear included
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (en && clr_err),
    .q   (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with a queue-based scoreboard.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cnt_valid = 1'b0;
  logic [7:0] cnt_in = '0;
  logic       clr_err = 1'b0;

  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_count, expected, expected2;
  logic [1:0] err_count2;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic       lk;
    logic       pl;
    int         cnt;
    logic [7:0] ex;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  count_monitor dut (
    .clk(clk), .rst(rst), .en(en), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected)
  );

  // same stimulus, 2-bit error counter to exercise saturation
  count_monitor #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cnt_valid(cnt_valid), .cnt_in(cnt_in),
    .clr_err(clr_err), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .expected(expected2)
  );

  // drive one cycle of inputs and queue the response expected after the edge
  task automatic s(input logic r, input logic e, input logic v, input logic [7:0] c,
                   input logic cl, input logic lk, input logic pl, input int cnt,
                   input logic [7:0] ex);
    exp_t t;
    @(negedge clk);
    rst = r; en = e; cnt_valid = v; cnt_in = c; clr_err = cl;
    t.lk = lk; t.pl = pl; t.cnt = cnt; t.ex = ex;
    sb.push_back(t);
  endtask

  // monitor: the DUT presents a registered response every edge
  always @(posedge clk) begin
    exp_t t;
    logic [1:0] c2;
    #1;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      nvec++;
      c2 = (t.cnt > 3) ? 2'd3 : 2'(t.cnt);
      if (locked !== t.lk) begin
        nerr++; $display("FAIL v%0d locked got %b want %b", nvec, locked, t.lk);
      end
      if (err_pulse !== t.pl) begin
        nerr++; $display("FAIL v%0d err_pulse got %b want %b", nvec, err_pulse, t.pl);
      end
      if (err_count !== 8'(t.cnt)) begin
        nerr++; $display("FAIL v%0d err_count got %0d want %0d", nvec, err_count, t.cnt);
      end
      if (expected !== t.ex) begin
        nerr++; $display("FAIL v%0d expected got %0d want %0d", nvec, expected, t.ex);
      end
      if (err_count2 !== c2) begin
        nerr++; $display("FAIL v%0d err_count_w2 got %0d want %0d", nvec, err_count2, c2);
      end
      if (locked2 !== t.lk || err_pulse2 !== t.pl || expected2 !== t.ex) begin
        nerr++; $display("FAIL v%0d w2_outputs got %b%b/%0d want %b%b/%0d", nvec,
                         locked2, err_pulse2, expected2, t.lk, t.pl, t.ex);
      end
    end
  end

  initial begin
    // reset overrides en, valid and clear
    s(1, 1, 1, 99, 1, 0, 0, 0, 1);
    // acquisition 10..14
    s(0, 1, 1, 10, 0, 0, 0, 0, 11);
    s(0, 1, 1, 11, 0, 0, 0, 0, 12);
    s(0, 1, 1, 12, 0, 0, 0, 0, 13);
    s(0, 1, 1, 13, 0, 0, 0, 0, 14);
    s(0, 1, 1, 14, 0, 1, 0, 0, 15);
    // wrap: lock at 252, then cross 255 -> 0
    s(1, 0, 0, 0, 0, 0, 0, 0, 1);
    s(0, 1, 1, 248, 0, 0, 0, 0, 249);
    s(0, 1, 1, 249, 0, 0, 0, 0, 250);
    s(0, 1, 1, 250, 0, 0, 0, 0, 251);
    s(0, 1, 1, 251, 0, 0, 0, 0, 252);
    s(0, 1, 1, 252, 0, 1, 0, 0, 253);
    s(0, 1, 1, 253, 0, 1, 0, 0, 254);
    s(0, 1, 1, 254, 0, 1, 0, 0, 255);
    s(0, 1, 1, 255, 0, 1, 0, 0, 0);
    s(0, 1, 1, 0,   0, 1, 0, 0, 1);
    s(0, 1, 1, 1,   0, 1, 0, 0, 2);
    // glitch: lock at 20, 21 ok, 50 bad (HOLD), 51 recovers
    s(1, 0, 0, 0, 0, 0, 0, 0, 1);
    s(0, 1, 1, 16, 0, 0, 0, 0, 17);
    s(0, 1, 1, 17, 0, 0, 0, 0, 18);
    s(0, 1, 1, 18, 0, 0, 0, 0, 19);
    s(0, 1, 1, 19, 0, 0, 0, 0, 20);
    s(0, 1, 1, 20, 0, 1, 0, 0, 21);
    s(0, 1, 1, 21, 0, 1, 0, 0, 22);
    s(0, 1, 1, 50, 0, 1, 1, 1, 51);
    s(0, 1, 1, 51, 0, 1, 0, 1, 52);
    s(0, 1, 0, 77, 0, 1, 0, 1, 52);
    // loss: three mismatches drop lock; 2-bit counter saturates on the third
    s(0, 1, 1, 5, 0, 1, 1, 2, 6);
    s(0, 1, 1, 9, 0, 1, 1, 3, 10);
    s(0, 1, 1, 2, 0, 0, 1, 4, 3);
    // relock needs four increments after the anchor
    s(0, 1, 1, 3, 0, 0, 0, 4, 4);
    s(0, 1, 1, 4, 0, 0, 0, 4, 5);
    s(0, 1, 1, 5, 0, 0, 0, 4, 6);
    s(0, 1, 1, 6, 0, 0, 0, 4, 7);
    s(0, 1, 1, 7, 0, 1, 0, 4, 8);
    // gaps and enable: nothing changes
    for (int i = 0; i < 5; i++) s(0, 1, 0, 8'(100 + i), 0, 1, 0, 4, 8);
    s(0, 0, 1, 77, 0, 1, 0, 4, 8);
    s(0, 1, 1, 8, 0, 1, 0, 4, 9);
    // clear with a match, then clear alongside a mismatch
    s(0, 1, 1, 9, 1, 1, 0, 0, 10);
    s(0, 1, 1, 40, 1, 1, 1, 1, 41);
    s(0, 1, 1, 60, 0, 1, 1, 2, 61);
    s(0, 1, 1, 70, 0, 0, 1, 3, 71);
    // relock then reset mid-HOLD
    s(0, 1, 1, 71, 0, 0, 0, 3, 72);
    s(0, 1, 1, 72, 0, 0, 0, 3, 73);
    s(0, 1, 1, 73, 0, 0, 0, 3, 74);
    s(0, 1, 1, 74, 0, 0, 0, 3, 75);
    s(0, 1, 1, 75, 0, 1, 0, 3, 76);
    s(0, 1, 1, 99, 0, 1, 1, 4, 100);
    s(1, 1, 1, 100, 0, 0, 0, 0, 1);
    s(0, 1, 0, 0, 0, 0, 0, 0, 1);
    // mismatches while acquiring are never errors
    s(0, 1, 1, 5, 0, 0, 0, 0, 6);
    s(0, 1, 1, 9, 0, 0, 0, 0, 10);
    s(0, 1, 1, 10, 0, 0, 0, 0, 11);
    s(0, 0, 0, 0, 0, 0, 0, 0, 11);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      nerr++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
